// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - opcodes, control-bit map and stage encodings shared by microcode_sequencer
package seq_pkg;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_NOP = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;

  // _N suffix marks active-low signals: asserted by clearing the bit
  localparam int CB_PC_INC          = 15;
  localparam int CB_PC_EN           = 14;
  localparam int CB_PC_LOAD         = 13;
  localparam int CB_MAR_ADDR_LOAD_N = 12;
  localparam int CB_MAR_MEM_LOAD_N  = 11;
  localparam int CB_RAM_EN_N        = 10;
  localparam int CB_RAM_LOAD_N      = 9;
  localparam int CB_IR_LOAD_N       = 8;
  localparam int CB_IR_EN_N         = 7;
  localparam int CB_REGA_LOAD_N     = 6;
  localparam int CB_REGA_EN         = 5;
  localparam int CB_ADDER_SUB       = 4;
  localparam int CB_REGB_EN         = 3;
  localparam int CB_REGB_LOAD_N     = 2;
  localparam int CB_OUT_LOAD_N      = 1;
  localparam int CB_FLAGS_LOAD_N    = 0;

  localparam logic [15:0] CTRL_IDLE = 16'h1FC7;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HOLD = 3'd6,
    ST_HALT = 3'd7
  } stage_t;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational (opcode, stage, flags) -> control word and last-stage marker
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0]  op,
  input  stage_t      stage,
  input  logic        c,
  input  logic        z,
  output logic [15:0] ctrl_next,
  output logic        is_last
);

  always_comb begin
    ctrl_next = CTRL_IDLE;
    is_last   = 1'b0;
    case (stage)
      ST_T0: begin
        ctrl_next[CB_PC_EN]           = 1'b1;
        ctrl_next[CB_MAR_ADDR_LOAD_N] = 1'b0;
      end
      ST_T1: ctrl_next[CB_PC_INC] = 1'b1;
      ST_T2: begin
        ctrl_next[CB_RAM_EN_N]  = 1'b0;
        ctrl_next[CB_IR_LOAD_N] = 1'b0;
        is_last = (op == OP_NOP) || (op == OP_HLT) || (op > OP_LDI);
      end
      ST_T3: begin
        is_last = op inside {OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_LDI};
        case (op)
          OP_JMP, OP_JC, OP_JZ: begin
            // untaken conditional jumps still consume T3, idle
            if ((op == OP_JMP) || (op == OP_JC && c) || (op == OP_JZ && z)) begin
              ctrl_next[CB_IR_EN_N] = 1'b0;
              ctrl_next[CB_PC_LOAD] = 1'b1;
            end
          end
          OP_OUT: begin
            ctrl_next[CB_REGA_EN]    = 1'b1;
            ctrl_next[CB_OUT_LOAD_N] = 1'b0;
          end
          OP_LDI: begin
            ctrl_next[CB_IR_EN_N]     = 1'b0;
            ctrl_next[CB_REGA_LOAD_N] = 1'b0;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_next[CB_IR_EN_N]         = 1'b0;
            ctrl_next[CB_MAR_ADDR_LOAD_N] = 1'b0;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        is_last = (op == OP_LDA);
        case (op)
          OP_LDA: begin
            ctrl_next[CB_RAM_EN_N]    = 1'b0;
            ctrl_next[CB_REGA_LOAD_N] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl_next[CB_RAM_EN_N]    = 1'b0;
            ctrl_next[CB_REGB_LOAD_N] = 1'b0;
          end
          OP_STA: begin
            ctrl_next[CB_REGA_EN]        = 1'b1;
            ctrl_next[CB_MAR_MEM_LOAD_N] = 1'b0;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        is_last = op inside {OP_ADD, OP_SUB, OP_STA};
        case (op)
          OP_ADD, OP_SUB: begin
            ctrl_next[CB_REGB_EN]      = 1'b1;
            ctrl_next[CB_REGA_LOAD_N]  = 1'b0;
            ctrl_next[CB_FLAGS_LOAD_N] = 1'b0;
            ctrl_next[CB_ADDER_SUB]    = (op == OP_SUB);
          end
          OP_STA: ctrl_next[CB_RAM_LOAD_N] = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - stage/hold/flag/HALT sequencer with negedge-registered control word; SINGLE_STEP_EN adds step_req
module microcode_sequencer
  import seq_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int HOLD_CYCLES = 1,
  parameter bit EARLY_END   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_in,
  input  logic                zero_in,
`ifdef SINGLE_STEP_EN
  input  logic                step_req,
`endif
  output logic [15:0]         ctrl,
  output logic [2:0]          stage,
  output logic                halted,
  output logic                instr_done
);

  stage_t      stage_q, stage_n;
  logic [3:0]  hold_q, hold_n;
  logic [3:0]  op;
  logic        c_q, z_q;
  logic        done_q, done_n;
  logic        flag_ld, stall, end_here, dec_last;
  logic [15:0] dec_ctrl, ctrl_next, ctrl_q;

  // any set bit above the decoded nibble demotes the opcode to NOP
  assign op = ((opcode >> 4) != '0) ? OP_NOP : opcode[3:0];

  seq_decode u_dec (
    .op       (op),
    .stage    (stage_q),
    .c        (c_q),
    .z        (z_q),
    .ctrl_next(dec_ctrl),
    .is_last  (dec_last)
  );

  assign end_here = EARLY_END ? dec_last : (stage_q == ST_T5);

`ifdef SINGLE_STEP_EN
  logic armed_q;
  assign stall = (stage_q == ST_T0) && !armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= (stage_n == ST_T0) && step_req;
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= ST_HOLD;
      hold_q  <= 4'(HOLD_CYCLES);
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      if (flag_ld) begin
        c_q <= carry_in;
        z_q <= zero_in;
      end
    end
  end

  always_comb begin
    stage_n = stage_q;
    hold_n  = hold_q;
    done_n  = 1'b0;
    flag_ld = 1'b0;
    case (stage_q)
      ST_HOLD: begin
        if (hold_q <= 4'd1) begin
          stage_n = ST_T0;
          hold_n  = 4'd0;
        end else begin
          hold_n = hold_q - 4'd1;
        end
      end
      ST_HALT: ;
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5: begin
        if (stall) begin
          stage_n = ST_T0;
        end else if (stage_q == ST_T2 && op == OP_HLT) begin
          stage_n = ST_HALT;
        end else if (end_here) begin
          stage_n = ST_T0;
          done_n  = 1'b1;
          flag_ld = (stage_q == ST_T5) && (op == OP_ADD || op == OP_SUB);
        end else begin
          stage_n = stage_t'(stage_q + 3'd1);
        end
      end
      default: stage_n = ST_HOLD;
    endcase
  end

  always_comb begin
    ctrl_next = CTRL_IDLE;
    if (stage_q <= ST_T5 && !stall) ctrl_next = dec_ctrl;
  end

  // negedge capture keeps the word settled for the next stage-advancing posedge
  always_ff @(negedge clk) begin
    ctrl_q <= ctrl_next;
  end

  assign ctrl       = ctrl_q;
  assign stage      = stage_q;
  assign halted     = (stage_q == ST_HALT);
  assign instr_done = done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - randomized self-checking bench for microcode_sequencer against a per-instruction word-table model
module tb_microcode_sequencer;

  localparam int OW   = 5;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          carry_in = 1'b0;
  logic          zero_in = 1'b0;
`ifdef SINGLE_STEP_EN
  logic          step_req = 1'b1;
`endif
  logic [15:0]   ctrl;
  logic [2:0]    stage;
  logic          halted;
  logic          instr_done;

  int n_tests = 0;
  int n_fail  = 0;
  int since_t0 = 0;
  logic mc = 1'b0;
  logic mz = 1'b0;

  always #5 clk = ~clk;

  microcode_sequencer #(.OPCODE_W(OW), .HOLD_CYCLES(HOLD), .EARLY_END(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .carry_in  (carry_in),
    .zero_in   (zero_in),
`ifdef SINGLE_STEP_EN
    .step_req  (step_req),
`endif
    .ctrl      (ctrl),
    .stage     (stage),
    .halted    (halted),
    .instr_done(instr_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] eff_op(input logic [OW-1:0] o);
    return (o[OW-1:4] != '0) ? 4'h1 : o[3:0];
  endfunction

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h4:                         return 5;
      4'h2, 4'h3, 4'h6:             return 6;
      4'h5, 4'h7, 4'h8, 4'h9, 4'hA: return 4;
      default:                      return 3;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input logic [3:0] op, input int k);
    if (k == 0) return 16'h4FC7;
    if (k == 1) return 16'h9FC7;
    if (k == 2) return 16'h1AC7;
    case (op)
      4'h7: return 16'h3F47;
      4'h8: return mc ? 16'h3F47 : 16'h1FC7;
      4'h9: return mz ? 16'h3F47 : 16'h1FC7;
      4'h5: return 16'h1FE5;
      4'hA: return 16'h1F07;
      4'h4: return (k == 3) ? 16'h0F47 : 16'h1B87;
      4'h2: return (k == 3) ? 16'h0F47 : (k == 4) ? 16'h1BC3 : 16'h1F8E;
      4'h3: return (k == 3) ? 16'h0F47 : (k == 4) ? 16'h1BC3 : 16'h1F9E;
      4'h6: return (k == 3) ? 16'h0F47 : (k == 4) ? 16'h17E7 : 16'h1DC7;
      default: return 16'h1FC7;
    endcase
  endfunction

  // starts #1 after the posedge that entered T0; ends #1 after the posedge back into T0
  task automatic run_instr(input logic [OW-1:0] o, input logic cy, input logic zr);
    logic [3:0] op;
    int len;
    op  = eff_op(o);
    len = instr_len(op);
    opcode = o;
    carry_in = cy;
    zero_in = zr;
    for (int k = 0; k < len; k++) begin
      check_eq($sformatf("stage op%0h T%0d", o, k), 32'(stage), 32'(k));
      @(negedge clk); #1;
      check_eq($sformatf("ctrl op%0h T%0d", o, k), 32'(ctrl), 32'(exp_word(op, k)));
      @(posedge clk); #1;
      since_t0++;
      if (k < len - 1) check_eq($sformatf("done_low op%0h T%0d", o, k), 32'(instr_done), 32'd0);
    end
    check_eq($sformatf("done_pulse op%0h", o), 32'(instr_done), 32'd1);
    if (op == 4'h2 || op == 4'h3) begin
      mc = cy;
      mz = zr;
    end
  endtask

  task automatic wait_t0(output int n);
    n = 0;
    while (stage !== 3'd0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("reach_t0", 32'(stage), 32'd0);
  endtask

  initial begin
    int n;
    logic [OW-1:0] o;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stage", 32'(stage), 32'd6);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_done", 32'(instr_done), 32'd0);
    @(negedge clk); #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'h1FC7);
    rst_n = 1'b1;
    wait_t0(n);
    check_eq("hold_len", 32'(n), 32'(HOLD));
    check_eq("hold_ctrl", 32'(ctrl), 32'h1FC7);

    since_t0 = 0;
    run_instr(5'h04, 1'b0, 1'b0);
    check_eq("done_at_lda", 32'(since_t0), 32'd5);
    run_instr(5'h02, 1'b0, 1'b0);
    check_eq("done_at_add", 32'(since_t0), 32'd11);
    run_instr(5'h05, 1'b0, 1'b0);
    check_eq("done_at_out", 32'(since_t0), 32'd15);

    run_instr(5'h03, 1'b1, 1'b1);
    run_instr(5'h09, 1'b0, 1'b0);
    run_instr(5'h03, 1'b1, 1'b0);
    run_instr(5'h09, 1'b0, 1'b0);
    run_instr(5'h08, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      o = OW'($urandom_range(1, (1 << OW) - 1));
      run_instr(o, 1'($urandom), 1'($urandom));
    end

    opcode = 5'h06;
    repeat (4) @(posedge clk);
    #1;
    check_eq("sta_t4", 32'(stage), 32'd4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("sta_abort_stage", 32'(stage), 32'd6);
    @(negedge clk); #1;
    check_eq("sta_abort_ctrl", 32'(ctrl), 32'h1FC7);
    rst_n = 1'b1;
    mc = 1'b0;
    mz = 1'b0;
    wait_t0(n);
    run_instr(5'h08, 1'b0, 1'b0);
    run_instr(5'h09, 1'b0, 1'b0);

`ifdef SINGLE_STEP_EN
    step_req = 1'b0;
    run_instr(5'h01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq("step_idle_ctrl", 32'(ctrl), 32'h1FC7);
      @(posedge clk); #1;
      check_eq("step_idle_stage", 32'(stage), 32'd0);
    end
    step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    run_instr(5'h0A, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("step_restall", 32'(stage), 32'd0);
    end
    step_req = 1'b1;
    @(posedge clk); #1;
`endif

    opcode = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("halt_stage", 32'(stage), 32'd7);
    check_eq("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check_eq("halt_ctrl", 32'(ctrl), 32'h1FC7);
      check_eq("halt_hold", 32'(stage), 32'd7);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("halt_clear", 32'(halted), 32'd0);
    check_eq("halt_rst_stage", 32'(stage), 32'd6);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
